mouse_cell_tracker: RTL and testbench

MOUSE_CELL_TRACKER -- requirements
Module: mouse_cell_tracker

---
 rtl/mouse_cell_tracker_pkg.sv | 18 +
 rtl/mouse_cell_tracker_if.sv | 18 +
 rtl/mouse_axis_accum.sv | 37 +++
 rtl/mouse_cell_tracker.sv | 92 +++++++++
 tb/tb_mouse_cell_tracker.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mouse_cell_tracker_pkg.sv
// Shared screen/grid geometry and framer state encoding for the mouse cursor
// tracker and the drawing datapath.
package mouse_cell_tracker_pkg;
  localparam int SCREEN_WIDTH   = 640;
  localparam int SCREEN_HEIGHT  = 480;
  localparam int CELL_DIMENSION = 5;
  localparam int MOTION_SHIFT   = 3;
  localparam int GRID_COLS      = SCREEN_WIDTH / CELL_DIMENSION;
  localparam int GRID_ROWS      = SCREEN_HEIGHT / CELL_DIMENSION;
  localparam int CELL_BITS      = $clog2((GRID_COLS > GRID_ROWS) ? GRID_COLS : GRID_ROWS);
  localparam int POS_BITS       = CELL_BITS + MOTION_SHIFT;
  localparam int X_LIMIT        = GRID_COLS << MOTION_SHIFT;
  localparam int Y_LIMIT        = GRID_ROWS << MOTION_SHIFT;
  localparam int X_CENTRE       = (GRID_COLS / 2) << MOTION_SHIFT;
  localparam int Y_CENTRE       = (GRID_ROWS / 2) << MOTION_SHIFT;

  typedef enum logic [1:0] {B0, B1, B2} frame_state_e;
endpackage

// File: rtl/mouse_cell_tracker_if.sv
// Byte stream in, cursor cell / button / status pulses out.
interface mouse_cell_tracker_if;
  import mouse_cell_tracker_pkg::*;
  logic [7:0]           iData;
  logic                 iDataValid;
  logic                 iRecentre;
  logic [CELL_BITS-1:0] oX_cell;
  logic [CELL_BITS-1:0] oY_cell;
  logic                 oLeft;
  logic                 oRight;
  logic                 oPacketValid;
  logic                 oSyncErr;

  modport slave  (input  iData, iDataValid, iRecentre,
                  output oX_cell, oY_cell, oLeft, oRight, oPacketValid, oSyncErr);
  modport master (output iData, iDataValid, iRecentre,
                  input  oX_cell, oY_cell, oLeft, oRight, oPacketValid, oSyncErr);
endinterface

// File: rtl/mouse_axis_accum.sv
// One cursor axis in mouse counts: adds (or subtracts) a 9-bit delta and
// saturates to 0..LIMIT-1; recentre overrides any motion.
module mouse_axis_accum
  import mouse_cell_tracker_pkg::*;
#(
  parameter int LIMIT  = X_LIMIT,
  parameter bit INVERT = 1'b0,
  parameter int CENTRE = X_CENTRE
) (
  input  logic                iClk,
  input  logic                iResetn,
  input  logic                apply,
  input  logic                zero,
  input  logic signed [8:0]   delta,
  input  logic                recentre,
  output logic [POS_BITS-1:0] pos
);
  localparam logic signed [11:0] MAX = 12'(LIMIT - 1);

  logic signed [11:0] d12, sum;
  logic [POS_BITS-1:0] sat;

  always_comb begin
    d12 = zero ? 12'sd0 : {{3{delta[8]}}, delta};
    sum = INVERT ? $signed({{(12-POS_BITS){1'b0}}, pos}) - d12
                 : $signed({{(12-POS_BITS){1'b0}}, pos}) + d12;
    if (sum[11])        sat = '0;
    else if (sum > MAX) sat = POS_BITS'(LIMIT - 1);
    else                sat = sum[POS_BITS-1:0];
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn)      pos <= POS_BITS'(CENTRE);
    else if (recentre) pos <= POS_BITS'(CENTRE);
    else if (apply)    pos <= sat;
  end
endmodule

// File: rtl/mouse_cell_tracker.sv
// PS/2 mouse packet framer with inter-byte timeout, driving a saturating
// cursor position expressed in grid cells.
module mouse_cell_tracker
  import mouse_cell_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input logic iClk,
  input logic iResetn,
  mouse_cell_tracker_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  frame_state_e state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [7:0] hdr, dxb;
  logic expired, sync_err, apply, hdr_ld, dx_ld;
  logic left, right, pkt_vld, sync_pls;
  logic [POS_BITS-1:0] pos_x, pos_y;

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state    <= B0;
      cnt      <= '0;
      hdr      <= '0;
      dxb      <= '0;
      left     <= 1'b0;
      right    <= 1'b0;
      pkt_vld  <= 1'b0;
      sync_pls <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pkt_vld  <= apply;
      sync_pls <= sync_err;
      if (hdr_ld) hdr <= bus.iData;
      if (dx_ld)  dxb <= bus.iData;
      if (apply) begin
        left  <= hdr[0];
        right <= hdr[1];
      end
    end
  end

  // An expiring packet falls back to B0 first, so a coincident strobe is a header candidate.
  always_comb begin
    expired  = (state != B0) && (cnt == TW'(TIMEOUT_CYCLES - 1));
    state_n  = expired ? B0 : state;
    sync_err = expired;
    apply    = 1'b0;
    hdr_ld   = 1'b0;
    dx_ld    = 1'b0;
    if (bus.iDataValid) begin
      case (state_n)
        B0: if (bus.iData[3]) begin
              hdr_ld  = 1'b1;
              state_n = B1;
            end else begin
              sync_err = 1'b1;
            end
        B1: begin
              dx_ld   = 1'b1;
              state_n = B2;
            end
        B2: begin
              apply   = 1'b1;
              state_n = B0;
            end
        default: state_n = B0;
      endcase
    end
    cnt_n = (state_n == B0 || bus.iDataValid) ? '0 : cnt + 1'b1;
  end

  mouse_axis_accum #(.LIMIT(X_LIMIT), .INVERT(1'b0), .CENTRE(X_CENTRE)) u_x (
    .iClk(iClk), .iResetn(iResetn), .apply(apply), .zero(hdr[6]),
    .delta({hdr[4], dxb}), .recentre(bus.iRecentre), .pos(pos_x)
  );

  // PS/2 positive Y is up while row 0 is the top, hence the inverted axis.
  mouse_axis_accum #(.LIMIT(Y_LIMIT), .INVERT(1'b1), .CENTRE(Y_CENTRE)) u_y (
    .iClk(iClk), .iResetn(iResetn), .apply(apply), .zero(hdr[7]),
    .delta({hdr[5], bus.iData}), .recentre(bus.iRecentre), .pos(pos_y)
  );

  assign bus.oX_cell      = pos_x[POS_BITS-1:MOTION_SHIFT];
  assign bus.oY_cell      = pos_y[POS_BITS-1:MOTION_SHIFT];
  assign bus.oLeft        = left;
  assign bus.oRight       = right;
  assign bus.oPacketValid = pkt_vld;
  assign bus.oSyncErr     = sync_pls;
endmodule

// File: tb/tb_mouse_cell_tracker.sv
// Scoreboard bench: a packet-level model predicts every status pulse and the
// cursor state that accompanies it; a monitor compares as pulses appear.
module tb_mouse_cell_tracker;
  import mouse_cell_tracker_pkg::*;
  localparam int T = 16;

  logic iClk = 1'b0;
  logic iResetn = 1'b0;
  always #5 iClk = ~iClk;

  mouse_cell_tracker_if bus();
  mouse_cell_tracker #(.TIMEOUT_CYCLES(T)) dut (.iClk(iClk), .iResetn(iResetn), .bus(bus));

  typedef struct { bit sync; int xc; int yc; bit l; bit r; } ev_t;
  ev_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  // reference model state
  int ms = 0, idle = 0, px = 512, py = 384;
  logic [7:0] mh = '0, mdx = '0;
  bit ml = 0, mr = 0;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic int clamp(int v, int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic void model(bit v, logic [7:0] d, bit rc);
    bit se = 0, ap = 0;
    int dx, dy;
    if (ms != 0 && idle >= T - 1) begin se = 1; ms = 0; end
    if (ms == 0) idle = 0;
    if (v) begin
      idle = 0;
      if (ms == 0) begin
        if (d[3]) begin mh = d; ms = 1; end else se = 1;
      end else if (ms == 1) begin
        mdx = d; ms = 2;
      end else begin
        dx = mh[6] ? 0 : (mh[4] ? int'(mdx) - 256 : int'(mdx));
        dy = mh[7] ? 0 : (mh[5] ? int'(d) - 256 : int'(d));
        px = clamp(px + dx, X_LIMIT - 1);
        py = clamp(py - dy, Y_LIMIT - 1);
        ml = mh[0]; mr = mh[1];
        ap = 1; ms = 0;
      end
    end else if (ms != 0) idle++;
    if (rc) begin px = X_CENTRE; py = Y_CENTRE; end
    if (se) exp_q.push_back('{1'b1, 0, 0, 1'b0, 1'b0});
    if (ap) exp_q.push_back('{1'b0, px >> MOTION_SHIFT, py >> MOTION_SHIFT, ml, mr});
  endfunction

  task automatic step(bit v, logic [7:0] d, bit rc);
    @(posedge iClk); #1;
    bus.iDataValid = v; bus.iData = d; bus.iRecentre = rc;
    model(v, d, rc);
  endtask

  task automatic send(logic [7:0] b, int gap = 0, bit rc = 0);
    repeat (gap) step(1'b0, 8'h00, 1'b0);
    step(1'b1, b, rc);
  endtask

  task automatic pkt(logic [7:0] h, logic [7:0] x, logic [7:0] y, bit rc = 0);
    send(h); send(x); send(y, 0, rc);
  endtask

  task automatic do_reset();
    @(posedge iClk); @(negedge iClk); #1;
    iResetn = 1'b0;
    bus.iDataValid = 1'b0; bus.iData = '0; bus.iRecentre = 1'b0;
    ms = 0; idle = 0; px = X_CENTRE; py = Y_CENTRE; mh = '0; mdx = '0; ml = 0; mr = 0;
    @(negedge iClk);
    check("rst_xcell", int'(bus.oX_cell), 64);
    check("rst_ycell", int'(bus.oY_cell), 48);
    check("rst_buttons", int'({bus.oLeft, bus.oRight}), 0);
    check("rst_pulses", int'({bus.oPacketValid, bus.oSyncErr}), 0);
    @(posedge iClk); #1;
    iResetn = 1'b1;
  endtask

  // monitor: every pulse must match the oldest outstanding prediction
  initial begin
    forever begin
      @(negedge iClk);
      if (iResetn && (bus.oPacketValid || bus.oSyncErr)) begin
        if (bus.oPacketValid && bus.oSyncErr) begin
          check("both_pulses", 1, 0);
          void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          check("unexpected_pulse", int'({bus.oPacketValid, bus.oSyncErr}), 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("pulse_kind_sync", int'(bus.oSyncErr), int'(e.sync));
          if (!e.sync && bus.oPacketValid) begin
            check("x_cell", int'(bus.oX_cell), e.xc);
            check("y_cell", int'(bus.oY_cell), e.yc);
            check("left", int'(bus.oLeft), int'(e.l));
            check("right", int'(bus.oRight), int'(e.r));
          end
        end
      end
    end
  end

  initial begin
    bus.iDataValid = 1'b0; bus.iData = '0; bus.iRecentre = 1'b0;
    do_reset();
    pkt(8'h08, 8'h05, 8'h00);                        // posX 517 -> cell 64
    do_reset();
    pkt(8'h18, 8'h00, 8'h00); pkt(8'h18, 8'h00, 8'h00); pkt(8'h18, 8'h00, 8'h00);
    pkt(8'h08, 8'hFF, 8'h00);                        // 255 -> cell 31
    do_reset();
    pkt(8'h09, 8'h00, 8'h10); pkt(8'h28, 8'h00, 8'hF0);
    send(8'h00); pkt(8'h08, 8'h01, 8'h00);           // dropped byte then normal
    do_reset();
    send(8'h08); send(8'h04); repeat (T) step(1'b0, 8'h00, 1'b0);
    pkt(8'h08, 8'h04, 8'h00);                        // posX 516 after timeout
    pkt(8'h0B, 8'h40, 8'h00, 1'b1);                  // recentre beats motion
    pkt(8'h48, 8'h7F, 8'h00);                        // X overflow: no X motion
    pkt(8'h28, 8'h00, 8'h00); pkt(8'h28, 8'h00, 8'h00); // Y saturates at bottom
    pkt(8'h98, 8'h80, 8'h7F);                        // Y overflow, dx -128
    send(8'h08); send(8'h05); do_reset();
    pkt(8'h08, 8'h02, 8'h00);                        // partial packet discarded
    send(8'h08); send(8'h03, T - 1); send(8'h08); send(8'h00); send(8'h00, T); send(8'h00);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      int gap;
      bit rc;
      b = 8'($urandom());
      if ($urandom_range(0, 9) != 0) b[3] = 1'b1;
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 2);
      rc = ($urandom_range(0, 24) == 0);
      send(b, gap, rc);
    end

    repeat (T + 4) step(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge iClk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
